// File: rtl/cmp_seq_exec.sv
// ----------------------------------------------------------------------------
// cmp_seq_exec
//
// Digit-serial compare/min/max executor for the eForth data path. It takes two
// stack operands (a = NOS, b = TOS) and a Forth compare opcode over a
// valid/ready handshake. It walks the operands one W-bit digit per cycle,
// starting at the MSB. It then returns either a Forth boolean (all ones or
// zero) or the selected operand, together with the {eq,neq,lt,lte,gt,gte}
// flag vector.
//
// Optional build macro: CMP_EARLY_EXIT_EN
//   defined   - SCAN stops on the first (MSB-most) differing digit.
//   undefined - every request scans all D digits (data-independent timing).
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   i_valid  in   request present (op, a, b)
//   i_ready  out  unit can accept a request
//   op       in   [3] 1=unsigned 0=signed, [2:0] EQ NE LT LE GT GE MIN MAX
//   a        in   first operand (NOS)
//   b        in   second operand (TOS)
//   o_valid  out  result available
//   o_ready  in   consumer takes the result
//   o        out  result word
//   flags    out  {eq,neq,lt,lte,gt,gte} of a relative to b
//   busy     out  high while in SCAN or DONE
// ----------------------------------------------------------------------------
module cmp_seq_exec #(
    parameter int N = 32,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [N-1:0] o,
    output logic [5:0]   flags,
    output logic         busy
);

    localparam int D  = N / W;
    localparam int KW = (D > 1) ? $clog2(D) : 1;
    localparam logic [N-1:0] SIGN_BIT = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d;
    logic [3:0]    op_q, op_d;
    logic [KW-1:0] k_q, k_d;
    logic          lt_q, lt_d, gt_q, gt_d;
    logic [N-1:0]  o_q, o_d;
    logic [5:0]    flags_q, flags_d;
    logic          o_valid_q, o_valid_d;
    logic          i_ready_q, i_ready_d;
    logic          busy_q, busy_d;

    // The operands are kept un-biased so MIN/MAX can return them directly.
    // For signed ops, flipping the sign bit maps two's complement onto an
    // unsigned order, so one unsigned digit compare serves both modes.
    logic [N-1:0] a_bias, b_bias;
    logic [W-1:0] dig_a, dig_b;
    logic         lt_now, gt_now, decided, eq_now, last_digit, cond;

    always_comb begin
        a_bias = op_q[3] ? a_q : (a_q ^ SIGN_BIT);
        b_bias = op_q[3] ? b_q : (b_q ^ SIGN_BIT);
        dig_a  = a_bias[int'(k_q) * W +: W];
        dig_b  = b_bias[int'(k_q) * W +: W];
        // The first difference seen (MSB-most) wins. A later digit cannot
        // overturn a relation that is already recorded.
        lt_now  = lt_q | (!gt_q & (dig_a < dig_b));
        gt_now  = gt_q | (!lt_q & (dig_a > dig_b));
        decided = lt_now | gt_now;
        eq_now  = !decided;
`ifdef CMP_EARLY_EXIT_EN
        last_digit = (k_q == '0) || decided;
`else
        last_digit = (k_q == '0);
`endif
        case (op_q[2:0])
            3'd0:    cond = eq_now;
            3'd1:    cond = !eq_now;
            3'd2:    cond = lt_now;
            3'd3:    cond = lt_now | eq_now;
            3'd4:    cond = gt_now;
            3'd5:    cond = gt_now | eq_now;
            3'd6:    cond = lt_now | eq_now;
            default: cond = gt_now | eq_now;
        endcase
    end

    // Next-state and registered-output logic for the IDLE/SCAN/DONE machine.
    // Every output comes from a flop, so nothing downstream observes a
    // combinational path through the digit comparator.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        k_d       = k_q;
        lt_d      = lt_q;
        gt_d      = gt_q;
        o_d       = o_q;
        flags_d   = flags_q;
        o_valid_d = o_valid_q;
        i_ready_d = i_ready_q;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                i_ready_d = 1'b1;
                if (i_valid && i_ready_q) begin
                    a_d       = a;
                    b_d       = b;
                    op_d      = op;
                    k_d       = KW'(D - 1);
                    lt_d      = 1'b0;
                    gt_d      = 1'b0;
                    state_d   = SCAN;
                    busy_d    = 1'b1;
                    i_ready_d = 1'b0;
                end
            end
            SCAN: begin
                lt_d = lt_now;
                gt_d = gt_now;
                if (last_digit) begin
                    if (op_q[2:1] == 2'b11) begin
                        o_d = cond ? a_q : b_q;
                    end else begin
                        o_d = cond ? {N{1'b1}} : {N{1'b0}};
                    end
                    flags_d   = {eq_now, !eq_now, lt_now, lt_now | eq_now,
                                 gt_now, gt_now | eq_now};
                    o_valid_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    k_d = k_q - KW'(1);
                end
            end
            default: begin
                if (o_ready) begin
                    o_valid_d = 1'b0;
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    i_ready_d = 1'b1;
                end
            end
        endcase
    end

    // State register. A reset aborts any operation in flight and drops the
    // result, so no stale o_valid pulse can escape.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            k_q       <= '0;
            lt_q      <= 1'b0;
            gt_q      <= 1'b0;
            o_q       <= '0;
            flags_q   <= '0;
            o_valid_q <= 1'b0;
            i_ready_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            k_q       <= k_d;
            lt_q      <= lt_d;
            gt_q      <= gt_d;
            o_q       <= o_d;
            flags_q   <= flags_d;
            o_valid_q <= o_valid_d;
            i_ready_q <= i_ready_d;
            busy_q    <= busy_d;
        end
    end

    assign i_ready = i_ready_q;
    assign o_valid = o_valid_q;
    assign o       = o_q;
    assign flags   = flags_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_cmp_seq_exec.sv
// ----------------------------------------------------------------------------
// tb_cmp_seq_exec
//
// Directed bench for cmp_seq_exec (N=32, W=4). A table of hand-computed
// vectors covers result, flags and latency. Hand-written sequences cover
// backpressure and reset during SCAN. Expected latencies follow
// CMP_EARLY_EXIT_EN when it is defined.
// ----------------------------------------------------------------------------
module tb_cmp_seq_exec;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expO;
      logic [5:0]  expFlags;
      int          latFull;
      int          latEarly;
   } vec_t;

   localparam logic [5:0] F_LT = 6'b011100;
   localparam logic [5:0] F_EQ = 6'b100101;
   localparam logic [5:0] F_GT = 6'b010011;

   logic        clk = 1'b0;
   logic        rst;
   logic        iValid;
   logic        iReady;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        oValid;
   logic        oReady;
   logic [31:0] o;
   logic [5:0]  flags;
   logic        busy;

   int   compared   = 0;
   int   mismatched = 0;
   vec_t vecs[13];

   cmp_seq_exec #(.N(32), .W(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .i_valid (iValid),
      .i_ready (iReady),
      .op      (op),
      .a       (a),
      .b       (b),
      .o_valid (oValid),
      .o_ready (oReady),
      .o       (o),
      .flags   (flags),
      .busy    (busy)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   // Compare an observed value against its expected value and record the result
   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Wait for i_ready, then issue one request. After the accept edge the
   // operand inputs are scrambled. Then count edges until o_valid.
   task automatic applyStimulus(input string tag, input logic [3:0] vOp,
                                input logic [31:0] vA, input logic [31:0] vB,
                                output int lat, output bit ok);
      int waitCnt;
      ok = 1'b0;
      lat = 0;
      waitCnt = 0;
      while (!iReady && waitCnt < 20) begin
         @(posedge clk); #1;
         waitCnt++;
      end
      if (!iReady) begin
         checkOutput({tag, "_accept_timeout"}, 32'(iReady), 32'd1);
         return;
      end
      op = vOp; a = vA; b = vB; iValid = 1'b1;
      @(posedge clk); #1;
      iValid = 1'b0;
      a = $urandom; b = $urandom; op = 4'($urandom);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
      while (!oValid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!oValid) begin
         checkOutput({tag, "_result_timeout"}, 32'(oValid), 32'd1);
         return;
      end
      ok = 1'b1;
   endtask

   // Main sequence: reset, vector table, backpressure, then reset mid-SCAN
   initial begin : mainSeq
      int lat;
      bit ok;
      int expLat;
      bit ghost;
      logic [31:0] holdO;
      logic [5:0]  holdF;

      //            op     a             b             o             flags full early
      vecs[0]  = '{4'd2,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, F_LT, 8, 8};
      vecs[1]  = '{4'd4,  32'hFFFFFFFF, 32'h00000000, 32'h00000000, F_LT, 8, 1};
      vecs[2]  = '{4'd12, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, F_GT, 8, 1};
      vecs[3]  = '{4'd0,  32'h7FFFFFFE, 32'h7FFFFFFE, 32'hFFFFFFFF, F_EQ, 8, 8};
      vecs[4]  = '{4'd12, 32'h10000000, 32'h00000000, 32'hFFFFFFFF, F_GT, 8, 1};
      vecs[5]  = '{4'd6,  32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFE, F_LT, 8, 1};
      vecs[6]  = '{4'd14, 32'hFFFFFFFE, 32'h00000001, 32'h00000001, F_GT, 8, 1};
      vecs[7]  = '{4'd7,  32'hFFFFFFFE, 32'h00000001, 32'h00000001, F_LT, 8, 1};
      vecs[8]  = '{4'd1,  32'h00000005, 32'h00000005, 32'h00000000, F_EQ, 8, 8};
      vecs[9]  = '{4'd3,  32'h12345678, 32'h12345679, 32'hFFFFFFFF, F_LT, 8, 8};
      vecs[10] = '{4'd5,  32'h80000000, 32'h7FFFFFFF, 32'h00000000, F_LT, 8, 1};
      vecs[11] = '{4'd13, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, F_GT, 8, 1};
      vecs[12] = '{4'd12, 32'h01000000, 32'h0000000F, 32'hFFFFFFFF, F_GT, 8, 2};

      rst = 1'b1; iValid = 1'b0; oReady = 1'b0; op = '0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_o_valid", 32'(oValid), 32'd0);
      checkOutput("rst_o",       o,           32'd0);
      checkOutput("rst_flags",   32'(flags),  32'd0);
      checkOutput("rst_busy",    32'(busy),   32'd0);
      checkOutput("rst_i_ready", 32'(iReady), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("post_rst_i_ready", 32'(iReady), 32'd1);

      for (int i = 0; i < 13; i++) begin
         applyStimulus($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, lat, ok);
         if (ok) begin
`ifdef CMP_EARLY_EXIT_EN
            expLat = vecs[i].latEarly;
`else
            expLat = vecs[i].latFull;
`endif
            checkOutput($sformatf("v%0d_o", i),       o,           vecs[i].expO);
            checkOutput($sformatf("v%0d_flags", i),   32'(flags),  32'(vecs[i].expFlags));
            checkOutput($sformatf("v%0d_latency", i), 32'(lat),    32'(expLat));
            oReady = 1'b1;
            @(posedge clk); #1;
            oReady = 1'b0;
            checkOutput($sformatf("v%0d_o_valid_clr", i), 32'(oValid), 32'd0);
         end
      end

      // Backpressure: the result must hold while o_ready is low. A request
      // presented in DONE must not be taken on the o_ready edge.
      applyStimulus("bp", 4'd12, 32'hFFFFFFFF, 32'h00000000, lat, ok);
      if (ok) begin
         holdO = o; holdF = flags;
         checkOutput("bp_first_o", holdO, 32'hFFFFFFFF);
         op = 4'd0; a = 32'h1; b = 32'h1; iValid = 1'b1;
         for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("bp%0d_o_valid", c), 32'(oValid), 32'd1);
            checkOutput($sformatf("bp%0d_o", c),       o,           holdO);
            checkOutput($sformatf("bp%0d_flags", c),   32'(flags),  32'(holdF));
            checkOutput($sformatf("bp%0d_i_ready", c), 32'(iReady), 32'd0);
         end
         oReady = 1'b1;
         @(posedge clk); #1;
         oReady = 1'b0;
         iValid = 1'b0;
         checkOutput("bp_release_o_valid", 32'(oValid), 32'd0);
         checkOutput("bp_release_busy",    32'(busy),   32'd0);
         checkOutput("bp_release_i_ready", 32'(iReady), 32'd1);
      end

      // Reset in the middle of SCAN: the result must be discarded
      op = 4'd0; a = 32'h7FFFFFFE; b = 32'h7FFFFFFE; iValid = 1'b1;
      @(posedge clk); #1;
      iValid = 1'b0;
      checkOutput("rs_busy", 32'(busy), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("rs_o_valid", 32'(oValid), 32'd0);
      checkOutput("rs_i_ready", 32'(iReady), 32'd0);
      checkOutput("rs_busy0",   32'(busy),   32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("rs_i_ready_back", 32'(iReady), 32'd1);
      ghost = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (oValid) ghost = 1'b1;
      end
      checkOutput("rs_no_ghost", 32'(ghost), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
